// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared PC control bits, fetch FSM encodings, defaults and opcodes
// Contents:
//   PC_*_BIT         bit indices of the decoder's pc control code
//   RESET_VECTOR_DEF default first fetch address after reset
//   QUEUE_DEPTH_DEF  instruction queue depth (fixed at 2)
//   fetch_state_t    fetch FSM state encodings
//   opcode_t         instruction opcodes (top nibble of an instruction word)
package instr_fetch_pkg;
    localparam int PC_SET_BIT  = 0;
    localparam int PC_OE_BIT   = 1;
    localparam int PC_LOCK_BIT = 2;
    localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;
    localparam int QUEUE_DEPTH_DEF = 2;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LOAD = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_JMP  = 4'h8,
        OP_JZ   = 4'h9,
        OP_HALT = 4'hF
    } opcode_t;
endpackage

// File: rtl/inst_queue.sv
// inst_queue: two-entry registered instruction queue with push, pop and flush
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset
//   i_flush           empty the queue (wins over push/pop)
//   i_push, i_data    write a word; ignored when full unless popping same cycle
//   i_pop             drop the head; ignored when empty
//   o_data            head word (16'h0000 when empty)
//   o_full, o_empty   occupancy flags
//   o_count           current occupancy (0..2)
module inst_queue
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_flush,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [15:0] i_data,
    output logic [15:0] o_data,
    output logic        o_full,
    output logic        o_empty,
    output logic [1:0]  o_count
);
    logic [15:0] mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        push_ok;
    logic        pop_ok;

    assign o_full  = count == 2'(DEPTH);
    assign o_empty = count == 2'd0;
    assign pop_ok  = i_pop && !o_empty;
    // when full, a same-cycle pop frees the head slot the push overwrites
    assign push_ok = i_push && (!o_full || pop_ok);
    assign o_data  = o_empty ? 16'h0000 : mem[rd_ptr];
    assign o_count = count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (i_flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            rd_ptr <= rd_ptr ^ pop_ok;
            wr_ptr <= wr_ptr ^ push_ok;
            count  <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !i_flush)
            mem[wr_ptr] <= i_data;
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC and fetch FSM feeding a two-entry instruction queue
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   i_pc_control_code   [0] pc set, [1] pc output enable, [2] pc lock
//   i_jump_addr         PC target loaded on pc set
//   o_addr_bus, o_mem_req  memory read request (address 0 when idle)
//   i_mem_ack, i_mem_data  read completion and returned word
//   o_inst_data, o_inst_valid, i_inst_ready  queue head handshake to decoder
//   o_pc                address of the next word to fetch
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int          QUEUE_DEPTH  = QUEUE_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [2:0]  i_pc_control_code,
    input  logic [15:0] i_jump_addr,
    output logic [15:0] o_addr_bus,
    output logic        o_mem_req,
    input  logic        i_mem_ack,
    input  logic [15:0] i_mem_data,
    output logic [15:0] o_inst_data,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [15:0] o_pc
);
    fetch_state_t state;
    fetch_state_t state_n;
    logic [15:0]  pc_n;
    logic [15:0]  addr_q;
    logic         armed;
    logic         pc_set;
    logic         pc_oe;
    logic         pc_lock;
    logic         pop;
    logic         push;
    logic         go;
    logic         q_full;
    logic         q_empty;
    logic [1:0]   q_count;
    logic [1:0]   count_n;

    assign pc_set  = i_pc_control_code[PC_SET_BIT];
    assign pc_oe   = i_pc_control_code[PC_OE_BIT];
    assign pc_lock = i_pc_control_code[PC_LOCK_BIT];
    assign o_inst_valid = !q_empty;
    assign pop     = o_inst_valid && i_inst_ready && !pc_set;
    assign push    = state == ST_REQ && i_mem_ack && !pc_set;
    assign count_n = q_count + {1'b0, push} - {1'b0, pop};
    // a pc set flushes the queue, so a slot is always free after it
    assign go = pc_oe && !pc_lock && armed && (pc_set || count_n < 2'd2);
    assign o_mem_req  = state != ST_IDLE;
    // addr_q holds the in-flight address even after a pc set moves o_pc
    assign o_addr_bus = o_mem_req ? addr_q : 16'h0000;

    always_comb begin
        pc_n    = pc_set ? i_jump_addr : (push ? o_pc + 16'd1 : o_pc);
        state_n = state;
        case (state)
            ST_IDLE:    state_n = go ? ST_REQ : ST_IDLE;
            ST_REQ:     state_n = i_mem_ack ? (go ? ST_REQ : ST_IDLE) : (pc_set ? ST_DISCARD : ST_REQ);
            ST_DISCARD: state_n = i_mem_ack ? ST_IDLE : ST_DISCARD;
            default:    state_n = ST_IDLE;
        endcase
    end

    // armed stays low for the first cycle after reset release so no request
    // is issued and no ack is accepted in that cycle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= ST_IDLE;
            o_pc   <= RESET_VECTOR;
            addr_q <= 16'h0000;
            armed  <= 1'b0;
        end else begin
            state  <= state_n;
            o_pc   <= pc_n;
            addr_q <= state_n == ST_REQ ? pc_n : addr_q;
            armed  <= 1'b1;
        end
    end

    inst_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_flush (pc_set),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  (i_mem_data),
        .o_data  (o_inst_data),
        .o_full  (q_full),
        .o_empty (q_empty),
        .o_count (q_count)
    );

    logic unused_full;
    assign unused_full = q_full;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized bench for instr_fetch against a transaction-level model
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [2:0]  i_pc_control_code = 3'b000;
    logic [15:0] i_jump_addr = 16'h0000;
    logic [15:0] o_addr_bus;
    logic        o_mem_req;
    logic        i_mem_ack = 1'b0;
    logic [15:0] i_mem_data = 16'h0000;
    logic [15:0] o_inst_data;
    logic        o_inst_valid;
    logic        i_inst_ready = 1'b0;
    logic [15:0] o_pc;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_pc;
    logic [15:0] m_addr;
    logic [15:0] m_q[$];
    bit          m_busy;
    bit          m_drop;
    bit          m_armed;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_VECTOR(16'h0000),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .i_pc_control_code (i_pc_control_code),
        .i_jump_addr       (i_jump_addr),
        .o_addr_bus        (o_addr_bus),
        .o_mem_req         (o_mem_req),
        .i_mem_ack         (i_mem_ack),
        .i_mem_data        (i_mem_data),
        .o_inst_data       (o_inst_data),
        .o_inst_valid      (o_inst_valid),
        .i_inst_ready      (i_inst_ready),
        .o_pc              (o_pc)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000;
        m_addr = 16'h0000;
        m_q.delete();
        m_busy = 0;
        m_drop = 0;
        m_armed = 0;
    endtask

    // one clock edge of the fetch unit described as transactions
    task automatic model_step();
        bit set, oe, lock, pop, clean, start;
        set  = i_pc_control_code[0];
        oe   = i_pc_control_code[1];
        lock = i_pc_control_code[2];
        pop   = m_q.size() != 0 && i_inst_ready && !set;
        clean = m_busy && i_mem_ack && !m_drop;
        if (pop)
            void'(m_q.pop_front());
        if (clean && !set) begin
            m_q.push_back(word_of(m_addr));
            m_pc = m_pc + 16'd1;
        end
        if (set) begin
            m_q.delete();
            m_pc = i_jump_addr;
        end
        start = (!m_busy || clean) && oe && !lock && m_armed && m_q.size() < 2;
        if (m_busy && i_mem_ack) begin
            m_busy = 0;
            m_drop = 0;
        end else if (m_busy && set) begin
            m_drop = 1;
        end
        if (start) begin
            m_busy = 1;
            m_drop = 0;
            m_addr = m_pc;
        end
        m_armed = 1;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_req"},   {15'b0, o_mem_req}, {15'b0, m_busy});
        check({tag, "_addr"},  o_addr_bus, m_busy ? m_addr : 16'h0000);
        check({tag, "_pc"},    o_pc, m_pc);
        check({tag, "_valid"}, {15'b0, o_inst_valid}, {15'b0, m_q.size() != 0});
        check({tag, "_data"},  o_inst_data, m_q.size() != 0 ? m_q[0] : 16'h0000);
    endtask

    // drive one cycle of inputs, clock it, then compare just after the edge
    task automatic cycle(input int set_p, input int oe_p, input int lock_p, input int rdy_p,
                         input int ack_p, input logic [15:0] jmp, input string tag);
        i_pc_control_code = {pct(lock_p), pct(oe_p), pct(set_p)};
        i_jump_addr  = jmp;
        i_inst_ready = pct(rdy_p);
        i_mem_ack    = pct(ack_p);
        i_mem_data   = m_busy ? word_of(m_addr) : 16'($urandom);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    // reset asserted mid-cycle with a late ack pending; ack held into the first cycle after release
    task automatic do_reset(input string tag);
        n_rst = 1'b0;
        i_mem_ack = 1'b1;
        #1;
        model_reset();
        compare_all({tag, "_async"});
        repeat (2) @(posedge clk);
        #1;
        compare_all({tag, "_held"});
        n_rst = 1'b1;
        cycle(0, 100, 0, 100, 100, 16'h0000, {tag, "_rel1"});
        cycle(0, 100, 0, 100, 100, 16'h0000, {tag, "_rel2"});
    endtask

    initial begin
        model_reset();
        #1;
        compare_all("por");
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (20) cycle(0, 100, 0, 100, 100, 16'h0000, "stream");

        do_reset("r1");
        repeat (10) cycle(0, 100, 0, 0, 100, 16'h0000, "stall");
        check("stall_pc", o_pc, 16'h0002);
        check("stall_req", {15'b0, o_mem_req}, 16'h0000);
        repeat (6) cycle(0, 100, 0, 100, 100, 16'h0000, "resume");

        do_reset("r2");
        repeat (3) cycle(0, 100, 0, 100, 0, 16'h0000, "pend");
        cycle(100, 100, 0, 100, 0, 16'h0040, "jset");
        check("jset_valid", {15'b0, o_inst_valid}, 16'h0000);
        repeat (2) cycle(0, 100, 0, 100, 0, 16'h0000, "jwait");
        cycle(0, 100, 0, 100, 100, 16'h0000, "jdrop");
        check("jdrop_valid", {15'b0, o_inst_valid}, 16'h0000);
        cycle(0, 100, 0, 100, 0, 16'h0000, "jnew");
        check("jnew_addr", o_addr_bus, 16'h0040);
        repeat (4) cycle(0, 100, 0, 100, 100, 16'h0000, "jrun");

        cycle(100, 100, 0, 0, 0, 16'hFFFF, "wset");
        repeat (4) cycle(0, 100, 0, 100, 100, 16'h0000, "wrap");

        repeat (6) cycle(0, 100, 0, 0, 60, 16'h0000, "fill");
        repeat (8) cycle(0, 100, 100, 50, 100, 16'h0000, "lock");
        cycle(100, 100, 100, 50, 50, 16'h1234, "setlock");
        repeat (4) cycle(0, 100, 100, 50, 100, 16'h0000, "locked");

        do_reset("r3");
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] j;
            j = pct(20) ? 16'(16'hFFFE + $urandom_range(1)) : 16'($urandom);
            cycle(5, 85, 15, 60, 50, j, "rand");
            if (i % 500 == 499)
                do_reset("rr");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
